// File: rtl/contador_tela_regressivo_if.sv
// contador_tela_regressivo_if: control and display bundle for the screen down-counter
interface contador_tela_regressivo_if #(parameter int WIDTH = 4);
  logic en, load, wrap, zero, tc;
  logic [WIDTH-1:0] load_val, Q;
  modport master(output en, load, load_val, wrap, input Q, zero, tc);
  modport slave(input en, load, load_val, wrap, output Q, zero, tc);
endinterface

// File: rtl/contador_tela_regressivo.sv
// contador_tela_regressivo: screen index counting TOP down to 0, one step per PRESCALE enabled cycles
module contador_tela_regressivo #(
  parameter int TOP      = 10,
  parameter int PRESCALE = 12,
  parameter int WIDTH    = 4
) (
  input  logic                         Ck,
  input  logic                         clear,
  contador_tela_regressivo_if.slave    bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] TOP_V   = WIDTH'(TOP);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0]    r_pre, w_pre_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt, w_q_step, w_load_sat;
  logic             r_tc, w_tc_nxt, w_step;
  always_comb begin
    w_step     = bus.en && r_pre == PRE_MAX;
    w_load_sat = bus.load_val > TOP_V ? TOP_V : bus.load_val;
    w_q_step   = r_q != '0 ? r_q - WIDTH'(1) : bus.wrap ? TOP_V : '0;
    w_q_nxt    = bus.load ? w_load_sat : w_step ? w_q_step : r_q;
    w_pre_nxt  = bus.load || w_step ? '0 : bus.en ? r_pre + PW'(1) : r_pre;
    // only a counted 1 -> 0 transition pulses tc; load and wrap-around never do
    w_tc_nxt   = !bus.load && w_step && r_q == WIDTH'(1);
  end
  always_ff @(posedge Ck or negedge clear) begin
    if (!clear) begin
      r_q   <= TOP_V;
      r_pre <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_pre <= w_pre_nxt;
      r_tc  <= w_tc_nxt;
    end
  end
  assign bus.Q    = r_q;
  assign bus.zero = r_q == '0;
  assign bus.tc   = r_tc;
endmodule

// File: tb/tb_contador_tela_regressivo.sv
// tb_contador_tela_regressivo: directed checks of the screen down-counter
module tb_contador_tela_regressivo;
  logic Ck = 1'b0;
  logic clear = 1'b0;
  int errors = 0;
  int checks = 0;
  contador_tela_regressivo_if #(.WIDTH(4)) bus();
  contador_tela_regressivo #(.TOP(10), .PRESCALE(12), .WIDTH(4)) dut (
    .Ck(Ck), .clear(clear), .bus(bus)
  );
  always #5 Ck = ~Ck;

  task automatic do_reset();
    @(negedge Ck);
    bus.en = 0; bus.load = 0; bus.load_val = 0; bus.wrap = 0;
    #2 clear = 0;
    @(negedge Ck);
    clear = 1;
  endtask

  task automatic test_reset();
    bus.en = 0; bus.load = 0; bus.load_val = 0; bus.wrap = 0;
    clear = 0;
    #12;
    checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL reset_q got=%0d exp=10", bus.Q); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", bus.tc); end
    @(negedge Ck);
    clear = 1;
  endtask

  task automatic test_countdown_hold();
    int tcs = 0;
    logic [3:0] exp;
    do_reset();
    bus.en = 1; bus.wrap = 0;
    for (int k = 1; k <= 132; k++) begin
      @(negedge Ck);
      exp = (k / 12) >= 10 ? 4'd0 : 4'(10 - k / 12);
      checks++; if (bus.Q !== exp) begin errors++; $display("FAIL hold_q edge=%0d got=%0d exp=%0d", k, bus.Q, exp); end
      if (bus.tc === 1'b1) tcs++;
      if (k == 120 || k == 121) begin
        checks++; if (bus.tc !== (k == 120)) begin errors++; $display("FAIL hold_tc edge=%0d got=%b exp=%b", k, bus.tc, k == 120); end
      end
      if (k >= 120) begin
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL hold_zero edge=%0d got=%b exp=1", k, bus.zero); end
      end
    end
    checks++; if (tcs != 1) begin errors++; $display("FAIL hold_tc_count got=%0d exp=1", tcs); end
  endtask

  task automatic test_wrap();
    int tcs = 0;
    int s;
    logic [3:0] exp;
    do_reset();
    bus.en = 1; bus.wrap = 1;
    for (int k = 1; k <= 144; k++) begin
      @(negedge Ck);
      s = k / 12;
      exp = s <= 10 ? 4'(10 - s) : 4'(21 - s);
      checks++; if (bus.Q !== exp) begin errors++; $display("FAIL wrap_q edge=%0d got=%0d exp=%0d", k, bus.Q, exp); end
      if (bus.tc === 1'b1) tcs++;
      if (k == 133) begin
        checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_reload got=%b exp=0", bus.tc); end
      end
    end
    checks++; if (tcs != 1) begin errors++; $display("FAIL wrap_tc_count got=%0d exp=1", tcs); end
  endtask

  task automatic test_load();
    do_reset();
    bus.en = 1; bus.load = 1; bus.load_val = 4'd15;
    @(negedge Ck);
    bus.load = 0;
    checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL load_sat got=%0d exp=10", bus.Q); end
    bus.en = 0; bus.load = 1; bus.load_val = 4'd5;
    @(negedge Ck);
    bus.load = 0;
    checks++; if (bus.Q !== 4'd5) begin errors++; $display("FAIL load_no_en got=%0d exp=5", bus.Q); end
    do_reset();
    bus.en = 1;
    repeat (11) @(negedge Ck);
    bus.load = 1; bus.load_val = 4'd3;
    @(negedge Ck);
    bus.load = 0;
    checks++; if (bus.Q !== 4'd3) begin errors++; $display("FAIL load_vs_step got=%0d exp=3", bus.Q); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL load_tc got=%b exp=0", bus.tc); end
    repeat (11) @(negedge Ck);
    checks++; if (bus.Q !== 4'd3) begin errors++; $display("FAIL load_pre_cleared got=%0d exp=3", bus.Q); end
    @(negedge Ck);
    checks++; if (bus.Q !== 4'd2) begin errors++; $display("FAIL load_next_step got=%0d exp=2", bus.Q); end
  endtask

  task automatic test_en_pause();
    do_reset();
    bus.en = 1;
    repeat (6) @(negedge Ck);
    bus.en = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Ck);
      checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL pause_q cyc=%0d got=%0d exp=10", k, bus.Q); end
    end
    bus.en = 1;
    repeat (5) @(negedge Ck);
    checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL pause_early got=%0d exp=10", bus.Q); end
    @(negedge Ck);
    checks++; if (bus.Q !== 4'd9) begin errors++; $display("FAIL pause_step got=%0d exp=9", bus.Q); end
  endtask

  task automatic test_async_clear();
    do_reset();
    bus.en = 1;
    repeat (79) @(negedge Ck);
    checks++; if (bus.Q !== 4'd4) begin errors++; $display("FAIL clr_setup got=%0d exp=4", bus.Q); end
    #2 clear = 0;
    #1;
    checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL clr_q got=%0d exp=10", bus.Q); end
    checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL clr_tc got=%b exp=0", bus.tc); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL clr_zero got=%b exp=0", bus.zero); end
    @(negedge Ck);
    clear = 1;
    repeat (11) @(negedge Ck);
    checks++; if (bus.Q !== 4'd10) begin errors++; $display("FAIL clr_early got=%0d exp=10", bus.Q); end
    @(negedge Ck);
    checks++; if (bus.Q !== 4'd9) begin errors++; $display("FAIL clr_first_step got=%0d exp=9", bus.Q); end
  endtask

  task automatic test_load_zero();
    do_reset();
    bus.load = 1; bus.load_val = 4'd0;
    @(negedge Ck);
    bus.load = 0;
    checks++; if (bus.Q !== 4'd0) begin errors++; $display("FAIL lz_q got=%0d exp=0", bus.Q); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL lz_zero got=%b exp=1", bus.zero); end
    bus.en = 1; bus.wrap = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Ck);
      checks++; if (bus.tc !== 1'b0) begin errors++; $display("FAIL lz_tc edge=%0d got=%b exp=0", k, bus.tc); end
      checks++; if (bus.Q !== (k == 12 ? 4'd10 : 4'd0)) begin errors++; $display("FAIL lz_wrap edge=%0d got=%0d exp=%0d", k, bus.Q, k == 12 ? 10 : 0); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown_hold();
    test_wrap();
    test_load();
    test_en_pause();
    test_async_clear();
    test_load_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
